soc_system_button_irq_master: RTL and testbench
===============================================

// Module: soc_system_button_irq_master
// PURPOSE
//  Avalon-MM initiator that services the button PIO edge-capture responder: on irq it reads
//  edge_capture (addr 3), clears exactly the bits it read, reads the input levels (addr 0),
//  and pushes one event into a local FIFO for downstream logic. Sits beside the button PIO
//  in place of a CPU ISR, giving hardware-only button handling.
// PARAMETERS
//  IRQ_MASK      4'hF  value written to irq_mask (addr 2) after every reset
//  FIFO_DEPTH    8     event FIFO entries; power of two, >= 2
//  READ_LATENCY  1     cycles from address presentation to readdata valid (>= 1)
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-high reset
//  enable       in   1   1 = service irq; 0 = finish current transaction, then hold in IDLE
//  irq          in   1   interrupt from the button PIO
//  av_address   out  2   PIO register address
//  av_chipselect out 1   high during every read and write access
//  av_write_n   out  1   active-low write strobe, one cycle per write
//  av_writedata out  32  write data; bits [31:4] always 0
//  av_readdata  in   32  PIO read data; only [3:0] used
//  evt_valid    out  1   FIFO not empty
//  evt_ready    in   1   consumer pops head when evt_valid && evt_ready
//  evt_data     out  24  [3:0] levels, [7:4] edges, [23:8] timestamp (0 without macro)
//  fifo_count   out  log2(FIFO_DEPTH)+1  occupancy
// BEHAVIOUR
//  - Reset: av_* = 0 except av_write_n = 1; evt_valid = 0, fifo_count = 0, FIFO flushed;
//    state = INIT. Reset mid-transaction aborts it immediately; INIT repeats on release.
//  - All av_* outputs registered; av_address/av_chipselect held constant through a read.
//  - INIT: write addr 2 = IRQ_MASK (av_write_n low 1 cycle) -> IDLE.
//  - IDLE: if enable && irq && FIFO not full -> RD_EDGE; else stay, bus idle
//    (chipselect 0, write_n 1). FIFO full: PIO keeps accumulating edges (bitwise OR).
//  - RD_EDGE: addr 3 for READ_LATENCY+1 cycles; sample readdata[3:0] into edge_r on the
//    last cycle. edge_r == 0 (spurious) -> IDLE, no write, no push.
//  - CLR: write addr 3, writedata = {28'b0, edge_r}; clears only sampled bits so edges that
//    arrive after the read stay pending -> RD_LVL.
//  - RD_LVL: addr 0, same timing as RD_EDGE, sample level_r -> PUSH.
//  - PUSH: write {ts_r, edge_r, level_r} to FIFO -> IDLE. One transaction = 4+2*READ_LATENCY
//    +1 cycles; irq is low again on re-entry to IDLE unless a new edge arrived.
//  - FIFO: show-ahead, evt_data valid combinationally with evt_valid. Push and pop in the
//    same cycle both succeed, count unchanged. Full is checked only in IDLE, so PUSH never
//    overflows. Pointers wrap modulo FIFO_DEPTH.
//  - enable deassert mid-transaction: transaction completes including PUSH.
// CONFIGURATION
//  BUTTON_EVT_TIMESTAMP_EN defined: free-running 16-bit cycle counter, reset to 0, wraps
//    0xFFFF->0; value latched into ts_r in the edge-sample cycle; carried in evt_data[23:8].
//  Not defined: no counter; evt_data[23:8] tied to 0.
// TESTING
//  1 Reset release -> next cycles: addr 2, writedata 0xF, write_n low exactly 1 cycle;
//    evt_valid 0, fifo_count 0.
//  2 PIO model edge_capture=4'b0101, in_port=4'b1010, irq=1 -> read addr 3, write addr 3
//    data 0x5, read addr 0; evt_valid=1 with evt_data[7:0]=0x5A; irq low afterwards.
//  3 evt_ready=0, 8 events queued, irq=1 -> fifo_count=8, no bus activity; one pop ->
//    service resumes, count back to 8.
//  4 irq=1 but addr-3 readdata=0 -> no write, no push, return to IDLE.
//  5 Assert reset during CLR -> outputs at reset values same cycle, FIFO empty; on release
//    INIT mask write repeats.
//  6 With BUTTON_EVT_TIMESTAMP_EN: event sampled at counter 0x0123 -> evt_data[23:8]=0x0123;
//    without the macro evt_data[23:8]=0.

Source files
------------

// File: rtl/soc_system_button_irq_master.sv
// Avalon-MM initiator that services a button PIO: on irq it reads and clears edge_capture, reads levels and queues one event.
// Define BUTTON_EVT_TIMESTAMP_EN to stamp each event with a free-running 16-bit cycle count.
module soc_system_button_irq_master #(
  parameter logic [3:0]  IRQ_MASK     = 4'hF,
  parameter int unsigned FIFO_DEPTH   = 8,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        irq,
  output logic [1:0]                  av_address,
  output logic                        av_chipselect,
  output logic                        av_write_n,
  output logic [31:0]                 av_writedata,
  input  logic [31:0]                 av_readdata,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [23:0]                 evt_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned LW = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

  localparam logic [2:0] S_INIT    = 3'd0;
  localparam logic [2:0] S_MASK    = 3'd1;
  localparam logic [2:0] S_IDLE    = 3'd2;
  localparam logic [2:0] S_RD_EDGE = 3'd3;
  localparam logic [2:0] S_CLR     = 3'd4;
  localparam logic [2:0] S_RD_LVL  = 3'd5;
  localparam logic [2:0] S_PUSH    = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [3:0]    edge_q, edge_d;
  logic [3:0]    level_q, level_d;
  logic [15:0]   ts_q;
  logic [1:0]    av_address_q, av_address_d;
  logic          av_cs_q, av_cs_d;
  logic          av_wn_q, av_wn_d;
  logic [31:0]   av_wd_q, av_wd_d;

  logic          fifo_full;
  logic          push, pop;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [23:0]   mem [FIFO_DEPTH];

  logic          unused_rd;
  assign unused_rd = ^av_readdata[31:4];

`ifdef BUTTON_EVT_TIMESTAMP_EN
  logic [15:0] ts_cnt_q, ts_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_cnt_q <= 16'h0;
      ts_q     <= 16'h0;
    end else begin
      ts_cnt_q <= ts_cnt_q + 16'd1;
      ts_q     <= ts_d;
    end
  end
`else
  assign ts_q = 16'h0;
`endif

  // Next state plus bus drive decoded from the state being entered, so bus outputs stay registered.
  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    edge_d       = edge_q;
    level_d      = level_q;
`ifdef BUTTON_EVT_TIMESTAMP_EN
    ts_d         = ts_q;
`endif
    av_address_d = 2'd0;
    av_cs_d      = 1'b0;
    av_wn_d      = 1'b1;
    av_wd_d      = 32'h0;

    case (state_q)
      S_INIT: state_d = S_MASK;
      S_MASK: state_d = S_IDLE;
      S_IDLE: if (enable && irq && !fifo_full) state_d = S_RD_EDGE;
      S_RD_EDGE: begin
        if (lat_q == LW'(READ_LATENCY)) begin
          lat_d  = '0;
          edge_d = av_readdata[3:0];
`ifdef BUTTON_EVT_TIMESTAMP_EN
          ts_d   = ts_cnt_q;
`endif
          state_d = (edge_d == 4'h0) ? S_IDLE : S_CLR;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_CLR: state_d = S_RD_LVL;
      S_RD_LVL: begin
        if (lat_q == LW'(READ_LATENCY)) begin
          lat_d   = '0;
          level_d = av_readdata[3:0];
          state_d = S_PUSH;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_PUSH:  state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase

    case (state_d)
      S_MASK: begin
        av_address_d = 2'd2;
        av_cs_d      = 1'b1;
        av_wn_d      = 1'b0;
        av_wd_d      = {28'h0, IRQ_MASK};
      end
      S_RD_EDGE: begin
        av_address_d = 2'd3;
        av_cs_d      = 1'b1;
      end
      S_CLR: begin
        av_address_d = 2'd3;
        av_cs_d      = 1'b1;
        av_wn_d      = 1'b0;
        av_wd_d      = {28'h0, edge_d};
      end
      S_RD_LVL: begin
        av_address_d = 2'd0;
        av_cs_d      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_INIT;
      lat_q        <= '0;
      edge_q       <= 4'h0;
      level_q      <= 4'h0;
      av_address_q <= 2'd0;
      av_cs_q      <= 1'b0;
      av_wn_q      <= 1'b1;
      av_wd_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      edge_q       <= edge_d;
      level_q      <= level_d;
      av_address_q <= av_address_d;
      av_cs_q      <= av_cs_d;
      av_wn_q      <= av_wn_d;
      av_wd_q      <= av_wd_d;
    end
  end

  assign av_address    = av_address_q;
  assign av_chipselect = av_cs_q;
  assign av_write_n    = av_wn_q;
  assign av_writedata  = av_wd_q;

  // Show-ahead event FIFO; full is only consulted in IDLE so PUSH can never overflow.
  assign fifo_full = (count_q == CW'(FIFO_DEPTH));
  assign push      = (state_q == S_PUSH);
  assign pop       = evt_valid && evt_ready;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {ts_q, edge_q, level_q};
  end

  assign evt_valid  = (count_q != '0);
  assign evt_data   = mem[rd_ptr_q];
  assign fifo_count = count_q;

endmodule

// File: tb/tb_soc_system_button_irq_master.sv
// Self-checking bench: button PIO responder model, bus monitor and an event queue as reference.
module tb_soc_system_button_irq_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        irq;
  logic [1:0]  av_address;
  logic        av_chipselect;
  logic        av_write_n;
  logic [31:0] av_writedata;
  logic [31:0] av_readdata = 32'h0;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [23:0] evt_data;
  logic [3:0]  fifo_count;

  // PIO model state
  logic [3:0]  edge_cap = 4'h0;
  logic [3:0]  pio_mask = 4'h0;
  logic [3:0]  in_port = 4'h0;
  logic [3:0]  inj = 4'h0;
  logic [3:0]  pio_clr;
  logic        force_irq = 1'b0;

  logic [34:0] bus_log[$];
  logic [7:0]  exp_q[$];
  logic        prev_rd = 1'b0;
  logic [1:0]  prev_addr = 2'd0;
  logic [15:0] tbcyc;
  logic [15:0] last_ts = 16'h0;
  int          checks = 0;
  int          errors = 0;
  bit          prod_done;

  always #5 clk = ~clk;

  assign irq = (|(edge_cap & pio_mask)) | force_irq;

  soc_system_button_irq_master dut (
    .clk(clk), .reset(reset), .enable(enable), .irq(irq),
    .av_address(av_address), .av_chipselect(av_chipselect), .av_write_n(av_write_n),
    .av_writedata(av_writedata), .av_readdata(av_readdata),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data), .fifo_count(fifo_count)
  );

  // PIO responder, one cycle read latency; upper readdata bits are junk
  always @(posedge clk) begin
    pio_clr = (av_chipselect && !av_write_n && av_address == 2'd3) ? av_writedata[3:0] : 4'h0;
    edge_cap <= (edge_cap & ~pio_clr) | inj;
    if (av_chipselect && !av_write_n && av_address == 2'd2) pio_mask <= av_writedata[3:0];
    if (av_chipselect && av_write_n) begin
      case (av_address)
        2'd0:    av_readdata <= {28'($urandom), in_port};
        2'd2:    av_readdata <= {28'($urandom), pio_mask};
        2'd3:    av_readdata <= {28'($urandom), edge_cap};
        default: av_readdata <= {28'($urandom), 4'h0};
      endcase
    end else begin
      av_readdata <= $urandom;
    end
  end

  always @(posedge clk or posedge reset) begin
    if (reset) tbcyc <= 16'h0;
    else       tbcyc <= tbcyc + 16'd1;
  end

  // Bus monitor: one entry per write cycle, one per read burst
  always @(negedge clk) begin
    if (av_chipselect && !av_write_n) begin
      bus_log.push_back({1'b1, av_address, av_writedata});
    end else if (av_chipselect && av_write_n) begin
      if (!(prev_rd && prev_addr == av_address)) bus_log.push_back({1'b0, av_address, 32'h0});
      else if (av_address == 2'd3) last_ts = tbcyc;
    end
    prev_rd   = av_chipselect && av_write_n;
    prev_addr = av_address;
  end

  function automatic logic [15:0] exp_ts();
`ifdef BUTTON_EVT_TIMESTAMP_EN
    return last_ts;
`else
    return 16'h0;
`endif
  endfunction

  task automatic inject(input logic [3:0] e);
    @(negedge clk);
    inj = e;
    @(posedge clk);
    #1 inj = 4'h0;
  endtask

  task automatic wait_count(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (fifo_count == 4'(target)) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_irq_low(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!irq) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    int n0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if ({av_chipselect, av_write_n, av_address, av_writedata} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin errors++; $display("FAIL reset_bus: got cs=%b wn=%b a=%0d wd=%h required 0 1 0 0", av_chipselect, av_write_n, av_address, av_writedata); end
    checks++; if ({evt_valid, fifo_count} !== 5'b0) begin errors++; $display("FAIL reset_fifo: got valid=%b count=%0d required 0 0", evt_valid, fifo_count); end
    n0 = bus_log.size();
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (bus_log.size() - n0 !== 1) begin errors++; $display("FAIL init_write_count: got %0d bus entries required 1", bus_log.size() - n0); end
    checks++; if (bus_log[n0] !== {1'b1, 2'd2, 32'hF}) begin errors++; $display("FAIL init_mask_write: got %h required %h", bus_log[n0], {1'b1, 2'd2, 32'hF}); end
    checks++; if ({evt_valid, fifo_count} !== 5'b0) begin errors++; $display("FAIL post_init_fifo: got valid=%b count=%0d required 0 0", evt_valid, fifo_count); end
  endtask

  task automatic test_single_event();
    int n0;
    bit ok;
    in_port = 4'b1010;
    n0 = bus_log.size();
    inject(4'b0101);
    wait_count(1, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: count=%0d required 1", fifo_count); end
    checks++; if (bus_log.size() - n0 !== 3) begin errors++; $display("FAIL single_bus_len: got %0d required 3", bus_log.size() - n0); end
    checks++; if (bus_log[n0] !== {1'b0, 2'd3, 32'h0}) begin errors++; $display("FAIL single_rd_edge: got %h", bus_log[n0]); end
    checks++; if (bus_log[n0+1] !== {1'b1, 2'd3, 32'h5}) begin errors++; $display("FAIL single_clr: got %h required %h", bus_log[n0+1], {1'b1, 2'd3, 32'h5}); end
    checks++; if (bus_log[n0+2] !== {1'b0, 2'd0, 32'h0}) begin errors++; $display("FAIL single_rd_lvl: got %h", bus_log[n0+2]); end
    checks++; if ({evt_valid, evt_data[7:0]} !== {1'b1, 8'h5A}) begin errors++; $display("FAIL single_evt: got valid=%b data=%h required 1 5a", evt_valid, evt_data[7:0]); end
    checks++; if (evt_data[23:8] !== exp_ts()) begin errors++; $display("FAIL single_ts: got %h required %h", evt_data[23:8], exp_ts()); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL single_irq_low: got %b required 0", irq); end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    checks++; if ({evt_valid, fifo_count} !== 5'b0) begin errors++; $display("FAIL single_pop: got valid=%b count=%0d required 0 0", evt_valid, fifo_count); end
  endtask

  task automatic test_fifo_full();
    int n0;
    bit ok;
    logic [3:0] lv, ed;
    evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      lv = 4'($urandom);
      ed = 4'(1 + $urandom % 15);
      in_port = lv;
      inject(ed);
      exp_q.push_back({ed, lv});
      wait_count(i + 1, 40, ok);
      checks++; if (!ok) begin errors++; $display("FAIL fill_timeout: count=%0d required %0d", fifo_count, i + 1); end
    end
    n0 = bus_log.size();
    lv = 4'($urandom);
    ed = 4'(1 + $urandom % 15);
    in_port = lv;
    inject(ed);
    repeat (20) @(negedge clk);
    checks++; if (bus_log.size() - n0 !== 0) begin errors++; $display("FAIL full_bus_quiet: got %0d bus entries required 0", bus_log.size() - n0); end
    checks++; if (fifo_count !== 4'd8) begin errors++; $display("FAIL full_count: got %0d required 8", fifo_count); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL full_irq_pending: got %b required 1", irq); end
    checks++; if (evt_data[7:0] !== exp_q[0]) begin errors++; $display("FAIL full_head: got %h required %h", evt_data[7:0], exp_q[0]); end
    void'(exp_q.pop_front());
    exp_q.push_back({ed, lv});
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    wait_count(8, 40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL full_resume: count=%0d required 8", fifo_count); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (evt_data[7:0] !== exp_q[0]) begin errors++; $display("FAIL drain_%0d: got %h required %h", i, evt_data[7:0], exp_q[0]); end
      void'(exp_q.pop_front());
      evt_ready = 1'b1;
      @(negedge clk);
    end
    evt_ready = 1'b0;
    checks++; if ({evt_valid, fifo_count} !== 5'b0) begin errors++; $display("FAIL drain_empty: got valid=%b count=%0d", evt_valid, fifo_count); end
  endtask

  task automatic test_spurious();
    int n0;
    bit seen;
    n0 = bus_log.size();
    seen = 1'b0;
    force_irq = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (bus_log.size() > n0) seen = 1'b1;
    end
    force_irq = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (!seen) begin errors++; $display("FAIL spurious_no_read: got no bus access required read of addr 3"); end
    checks++; if (bus_log.size() - n0 !== 1) begin errors++; $display("FAIL spurious_bus_len: got %0d entries required 1", bus_log.size() - n0); end
    checks++; if (bus_log[n0] !== {1'b0, 2'd3, 32'h0}) begin errors++; $display("FAIL spurious_rd: got %h", bus_log[n0]); end
    checks++; if ({evt_valid, fifo_count} !== 5'b0) begin errors++; $display("FAIL spurious_push: got valid=%b count=%0d required 0 0", evt_valid, fifo_count); end
  endtask

  task automatic test_enable();
    int n0;
    bit ok;
    enable = 1'b0;
    n0 = bus_log.size();
    in_port = 4'h3;
    inject(4'h8);
    repeat (10) @(negedge clk);
    checks++; if (bus_log.size() - n0 !== 0 || fifo_count !== 4'd0) begin errors++; $display("FAIL disabled_idle: got %0d entries count=%0d required 0 0", bus_log.size() - n0, fifo_count); end
    enable = 1'b1;
    wait_count(1, 40, ok);
    checks++; if (!ok || evt_data[7:0] !== 8'h83) begin errors++; $display("FAIL enable_resume: got ok=%b data=%h required 1 83", ok, evt_data[7:0]); end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    n0 = bus_log.size();
    in_port = 4'hC;
    inject(4'h2);
    for (int i = 0; i < 20 && bus_log.size() == n0; i++) @(negedge clk);
    enable = 1'b0;
    wait_count(1, 40, ok);
    checks++; if (!ok || evt_data[7:0] !== 8'h2C) begin errors++; $display("FAIL disable_mid: got ok=%b data=%h required 1 2c", ok, evt_data[7:0]); end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    enable = 1'b1;
  endtask

  task automatic test_reset_mid();
    int n0;
    bit ok, hit;
    evt_ready = 1'b0;
    in_port = 4'h6;
    inject(4'h1);
    wait_count(1, 40, ok);
    in_port = 4'h9;
    inject(4'h4);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      if (av_chipselect && !av_write_n && av_address == 2'd3) hit = 1'b1;
    end
    checks++; if (!hit) begin errors++; $display("FAIL rstmid_no_clr: got no clear write required one"); end
    reset = 1'b1;
    #1;
    checks++; if ({av_chipselect, av_write_n, av_address, av_writedata} !== {1'b0, 1'b1, 2'd0, 32'h0}) begin errors++; $display("FAIL rstmid_bus: got cs=%b wn=%b a=%0d wd=%h", av_chipselect, av_write_n, av_address, av_writedata); end
    checks++; if ({evt_valid, fifo_count} !== 5'b0) begin errors++; $display("FAIL rstmid_flush: got valid=%b count=%0d required 0 0", evt_valid, fifo_count); end
    exp_q.delete();
    repeat (2) @(negedge clk);
    n0 = bus_log.size();
    reset = 1'b0;
    wait_count(1, 60, ok);
    checks++; if (bus_log[n0] !== {1'b1, 2'd2, 32'hF}) begin errors++; $display("FAIL rstmid_init: got %h required %h", bus_log[n0], {1'b1, 2'd2, 32'hF}); end
    checks++; if (!ok || evt_data[7:0] !== 8'h49) begin errors++; $display("FAIL rstmid_reservice: got ok=%b data=%h required 1 49", ok, evt_data[7:0]); end
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic test_random_stream();
    int guard;
    prod_done = 1'b0;
    fork
      begin
        bit ok;
        logic [3:0] lv, ed;
        for (int i = 0; i < 24; i++) begin
          lv = 4'($urandom);
          ed = 4'(1 + $urandom % 15);
          in_port = lv;
          inject(ed);
          exp_q.push_back({ed, lv});
          wait_irq_low(400, ok);
          checks++; if (!ok) begin errors++; $display("FAIL stream_irq_timeout: event %0d", i); end
          repeat (4) @(negedge clk);
        end
        prod_done = 1'b1;
      end
      begin
        guard = 0;
        while (guard < 20000) begin
          @(negedge clk);
          guard++;
          if (prod_done && exp_q.size() == 0) break;
          evt_ready = 1'($urandom);
          if (evt_ready && evt_valid) begin
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL stream_extra: got %h required no event", evt_data[7:0]); end
            else begin
              if (evt_data[7:0] !== exp_q[0]) begin errors++; $display("FAIL stream_data: got %h required %h", evt_data[7:0], exp_q[0]); end
              void'(exp_q.pop_front());
            end
          end
        end
        evt_ready = 1'b0;
      end
    join
    @(negedge clk);
    checks++; if ({evt_valid, fifo_count} !== 5'b0 || exp_q.size() != 0) begin errors++; $display("FAIL stream_end: got valid=%b count=%0d pending=%0d required 0 0 0", evt_valid, fifo_count, exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_single_event();
    test_fifo_full();
    test_spurious();
    test_enable();
    test_reset_mid();
    test_random_stream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
